caliptra_apb_cmd_driver: RTL and testbench

CALIPTRA_APB_CMD_DRIVER -- requirements
Module: caliptra_apb_cmd_driver

---
 rtl/caliptra_apb_cmd_pkg.sv | 37 +++
 rtl/caliptra_apb_cmd_timeout_ctr.sv | 27 ++
 rtl/caliptra_apb_cmd_driver.sv | 136 +++++++++++++
 tb/tb_caliptra_apb_cmd_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_apb_cmd_pkg.sv
// Shared types for the Caliptra APB command driver: FSM states and request/response records.
// Bus widths come from CALIPTRA_APB_*_WIDTH; the timeout feature is enabled by CALIPTRA_APB_CMD_TIMEOUT_EN.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

package caliptra_apb_cmd_pkg;
   localparam int APB_ADDR_W = `CALIPTRA_APB_ADDR_WIDTH;
   localparam int APB_DATA_W = `CALIPTRA_APB_DATA_WIDTH;
   localparam int APB_USER_W = `CALIPTRA_APB_USER_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } cmd_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_USER_W-1:0] user;
   } cmd_req_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } cmd_resp_t;
endpackage

// File: rtl/caliptra_apb_cmd_timeout_ctr.sv
// ACCESS-phase cycle counter; expired is high during the TIMEOUT_CYCLES-th enabled cycle.
// Only instanced when CALIPTRA_APB_CMD_TIMEOUT_EN is defined.
module caliptra_apb_cmd_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_reg;

   // Holds k-1 during the k-th ACCESS cycle and saturates at the final count.
   always_ff @(posedge clk) begin
      if (srst || clear) begin
         cnt_reg <= '0;
      end else if (enable && (cnt_reg != LAST)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign expired = enable && (cnt_reg == LAST);
endmodule

// File: rtl/caliptra_apb_cmd_driver.sv
// Single-outstanding APB master: accepts one command, runs SETUP/ACCESS, holds the response until consumed.
// Define CALIPTRA_APB_CMD_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without pready.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

module caliptra_apb_cmd_driver
   import caliptra_apb_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_W         = `CALIPTRA_APB_ADDR_WIDTH,
   parameter int DATA_W         = `CALIPTRA_APB_DATA_WIDTH,
   parameter int USER_W         = `CALIPTRA_APB_USER_WIDTH
) (
   input  logic              core_clk,
   input  logic              core_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [USER_W-1:0] req_user,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              resp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [USER_W-1:0] pauser,
   input  logic              pready,
   input  logic              pslverr,
   input  logic [DATA_W-1:0] prdata
);
   cmd_state_e state_reg;
   cmd_req_t   req_reg;
   cmd_resp_t  resp_reg;
   logic       req_ready_reg;
   logic       resp_valid_reg;
   logic       psel_reg;
   logic       penable_reg;
   logic       timeout_hit;

`ifdef CALIPTRA_APB_CMD_TIMEOUT_EN
   caliptra_apb_cmd_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk     (core_clk),
      .srst    (core_rst),
      .clear   (state_reg == ST_SETUP),
      .enable  (state_reg == ST_ACCESS),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_reg      <= ST_IDLE;
         req_ready_reg  <= 1'b0;
         psel_reg       <= 1'b0;
         penable_reg    <= 1'b0;
         resp_valid_reg <= 1'b0;
         req_reg        <= '0;
         resp_reg       <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid && req_ready_reg) begin
                  req_reg.write <= req_write;
                  req_reg.addr  <= req_addr;
                  req_reg.wdata <= req_wdata;
                  req_reg.user  <= req_user;
                  req_ready_reg <= 1'b0;
                  psel_reg      <= 1'b1;
                  state_reg     <= ST_SETUP;
               end else begin
                  req_ready_reg <= 1'b1;
               end
            end
            ST_SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready takes priority over a timeout landing in the same cycle.
               if (pready) begin
                  resp_reg.rdata   <= (!req_reg.write && !pslverr) ? prdata : '0;
                  resp_reg.err     <= pslverr;
                  resp_reg.timeout <= 1'b0;
               end else if (timeout_hit) begin
                  resp_reg.rdata   <= '0;
                  resp_reg.err     <= 1'b1;
                  resp_reg.timeout <= 1'b1;
               end
               if (pready || timeout_hit) begin
                  psel_reg       <= 1'b0;
                  penable_reg    <= 1'b0;
                  resp_valid_reg <= 1'b1;
                  state_reg      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  req_ready_reg  <= 1'b1;
                  state_reg      <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = req_ready_reg;
   assign resp_valid   = resp_valid_reg;
   assign resp_rdata   = resp_reg.rdata;
   assign resp_err     = resp_reg.err;
   assign resp_timeout = resp_reg.timeout;
   assign psel         = psel_reg;
   assign penable      = penable_reg;
   assign pwrite       = req_reg.write;
   assign paddr        = req_reg.addr;
   assign pwdata       = req_reg.wdata;
   assign pauser       = req_reg.user;
endmodule

// File: tb/tb_caliptra_apb_cmd_driver.sv
// Directed bench for caliptra_apb_cmd_driver; timeout scenarios follow CALIPTRA_APB_CMD_TIMEOUT_EN.
module tb_caliptra_apb_cmd_driver;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int UW = 32;

   logic          core_clk = 1'b0;
   logic          core_rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [UW-1:0] req_user = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;
   logic          resp_timeout;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [UW-1:0] pauser;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;
   logic [DW-1:0] prdata = '0;

   int total = 0;
   int bad = 0;

   always #5 core_clk = ~core_clk;

   caliptra_apb_cmd_driver #(
      .TIMEOUT_CYCLES(16), .ADDR_W(AW), .DATA_W(DW), .USER_W(UW)
   ) dut (
      .core_clk(core_clk), .core_rst(core_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .resp_timeout(resp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pauser(pauser),
      .pready(pready), .pslverr(pslverr), .prdata(prdata)
   );

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   // Issues one command and plays the completer; returns observed timing without consuming the response.
   task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] u, input logic [31:0] rd, input logic se,
                          input int waits, output int hs_wait, output int lat,
                          output int psel_cnt, output int acc_cnt, output bit stable_ok);
      hs_wait = 0; lat = -1; psel_cnt = 0; acc_cnt = 0; stable_ok = 1'b1;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_user = u;
      while (!req_ready && hs_wait < 50) begin
         tick();
         hs_wait++;
      end
      tick();
      req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~wd; req_user = ~u;
      for (int c = 1; c <= 200; c++) begin
         if (resp_valid) begin
            lat = c;
            break;
         end
         if (penable && !psel) stable_ok = 1'b0;
         if (psel) begin
            psel_cnt++;
            if (paddr !== a || pwdata !== wd || pauser !== u || pwrite !== wr) stable_ok = 1'b0;
         end
         if (psel && penable) begin
            acc_cnt++;
            pready = (acc_cnt > waits); prdata = rd; pslverr = se;
         end else begin
            pready = 1'b0; prdata = 32'h5555_AAAA; pslverr = 1'b1;
         end
         tick();
      end
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      core_rst = 1'b1;
      tick(); tick();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
      total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_apb_ctl got=%b want=000", {psel, penable, pwrite}); end
      total++; if (paddr !== '0 || pwdata !== '0 || pauser !== '0) begin bad++; $display("FAIL reset_apb_bus got=%h/%h/%h want=0", paddr, pwdata, pauser); end
      total++; if ({resp_valid, resp_err, resp_timeout} !== 3'b000 || resp_rdata !== '0) begin bad++; $display("FAIL reset_resp got=%b%b%b/%h want=0", resp_valid, resp_err, resp_timeout, resp_rdata); end
      core_rst = 1'b0;
      tick();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
   endtask

   task automatic test_write();
      int hs, lat, pc, ac; bit st;
      run_cmd(1'b1, 32'h3003_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, hs, lat, pc, ac, st);
      total++; if (hs !== 0) begin bad++; $display("FAIL write_hs_wait got=%0d want=0", hs); end
      total++; if (pc !== 2) begin bad++; $display("FAIL write_psel_cycles got=%0d want=2", pc); end
      total++; if (lat !== 3) begin bad++; $display("FAIL write_latency got=%0d want=3", lat); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL write_bus_stable got=%b want=1", st); end
      total++; if ({resp_err, resp_timeout} !== 2'b00 || resp_rdata !== 32'h0) begin bad++; $display("FAIL write_resp got=%b%b/%h want=00/0", resp_err, resp_timeout, resp_rdata); end
      total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL write_resp_psel got=%b%b want=00", psel, penable); end
      consume();
      total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL write_consume got=%b%b want=01", resp_valid, req_ready); end
   endtask

   task automatic test_read_wait();
      int hs, lat, pc, ac; bit st;
      run_cmd(1'b0, 32'h3003_0004, 32'h0, 32'h0000_0001, 32'h1234_5678, 1'b0, 2, hs, lat, pc, ac, st);
      total++; if (lat !== 5) begin bad++; $display("FAIL read_wait_latency got=%0d want=5", lat); end
      total++; if (ac !== 3) begin bad++; $display("FAIL read_wait_access got=%0d want=3", ac); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL read_wait_stable got=%b want=1", st); end
      total++; if (resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0) begin bad++; $display("FAIL read_wait_resp got=%h/%b want=12345678/0", resp_rdata, resp_err); end
      consume();
   endtask

   task automatic test_read_err();
      int hs, lat, pc, ac; bit st;
      run_cmd(1'b0, 32'h3003_0008, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b1, 1, hs, lat, pc, ac, st);
      total++; if (lat !== 4) begin bad++; $display("FAIL read_err_latency got=%0d want=4", lat); end
      total++; if ({resp_err, resp_timeout} !== 2'b10) begin bad++; $display("FAIL read_err_flags got=%b%b want=10", resp_err, resp_timeout); end
      total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL read_err_rdata got=%h want=0", resp_rdata); end
      consume();
   endtask

   task automatic test_back_to_back();
      int hs, lat, pc, ac; bit st;
      run_cmd(1'b0, 32'h3003_000C, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 0, hs, lat, pc, ac, st);
      total++; if (lat !== 3) begin bad++; $display("FAIL bp_latency got=%0d want=3", lat); end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3003_0014; req_wdata = 32'h0BAD_F00D; req_user = 32'h2;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/cafef00d/0", i, resp_valid, resp_rdata, resp_err); end
         total++; if (req_ready !== 1'b0 || psel !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b%b want=00", i, req_ready, psel); end
      end
      consume();
      total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b%b want=01", resp_valid, req_ready); end
      run_cmd(1'b1, 32'h3003_0014, 32'h0BAD_F00D, 32'h2, 32'h0, 1'b0, 0, hs, lat, pc, ac, st);
      total++; if (hs !== 0) begin bad++; $display("FAIL bp_next_hs got=%0d want=0", hs); end
      total++; if (lat !== 3 || st !== 1'b1) begin bad++; $display("FAIL bp_next got=%0d/%b want=3/1", lat, st); end
      consume();
   endtask

   task automatic test_reset_mid();
      int hs, lat, pc, ac; bit st;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3003_0018; req_wdata = 32'h7777_7777; req_user = 32'h3;
      tick();
      req_valid = 1'b0;
      tick();
      total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL mid_in_access got=%b%b want=11", psel, penable); end
      core_rst = 1'b1;
      tick();
      core_rst = 1'b0;
      total++; if ({psel, penable, resp_valid} !== 3'b000) begin bad++; $display("FAIL mid_abort got=%b%b%b want=000", psel, penable, resp_valid); end
      resp_ready = 1'b1;
      tick(); tick();
      resp_ready = 1'b0;
      total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_after got=%b%b want=01", resp_valid, req_ready); end
      run_cmd(1'b1, 32'h3003_0020, 32'h1122_3344, 32'h4, 32'h0, 1'b0, 1, hs, lat, pc, ac, st);
      total++; if (lat !== 4 || st !== 1'b1 || resp_err !== 1'b0) begin bad++; $display("FAIL mid_fresh got=%0d/%b/%b want=4/1/0", lat, st, resp_err); end
      consume();
   endtask

   task automatic test_timeout();
      int hs, lat, pc, ac; bit st;
`ifdef CALIPTRA_APB_CMD_TIMEOUT_EN
      run_cmd(1'b0, 32'h3003_0024, 32'h0, 32'h0, 32'h9999_9999, 1'b0, 1000, hs, lat, pc, ac, st);
      total++; if (ac !== 16 || pc !== 17) begin bad++; $display("FAIL to_abort_cycles got=%0d/%0d want=16/17", ac, pc); end
      total++; if (lat !== 18) begin bad++; $display("FAIL to_abort_latency got=%0d want=18", lat); end
      total++; if ({resp_err, resp_timeout} !== 2'b11 || resp_rdata !== 32'h0) begin bad++; $display("FAIL to_abort_resp got=%b%b/%h want=11/0", resp_err, resp_timeout, resp_rdata); end
      consume();
      run_cmd(1'b0, 32'h3003_0028, 32'h0, 32'h0, 32'h600D_600D, 1'b0, 15, hs, lat, pc, ac, st);
      total++; if (ac !== 16 || lat !== 18) begin bad++; $display("FAIL to_edge_cycles got=%0d/%0d want=16/18", ac, lat); end
      total++; if ({resp_err, resp_timeout} !== 2'b00 || resp_rdata !== 32'h600D_600D) begin bad++; $display("FAIL to_edge_resp got=%b%b/%h want=00/600d600d", resp_err, resp_timeout, resp_rdata); end
      consume();
`else
      run_cmd(1'b0, 32'h3003_0024, 32'h0, 32'h0, 32'h9999_9999, 1'b0, 20, hs, lat, pc, ac, st);
      total++; if (ac !== 21 || lat !== 23) begin bad++; $display("FAIL no_to_cycles got=%0d/%0d want=21/23", ac, lat); end
      total++; if ({resp_err, resp_timeout} !== 2'b00 || resp_rdata !== 32'h9999_9999) begin bad++; $display("FAIL no_to_resp got=%b%b/%h want=00/99999999", resp_err, resp_timeout, resp_rdata); end
      consume();
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_read_err();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
